// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard control: forwarding, load-use stall, syscall drain
//
// Purpose:
//   Drives stall, flush and operand-forwarding controls from the EX-side
//   fields of ID/EX plus the MEM and WB destination fields. A syscall in EX
//   freezes the front end, waits DRAIN_CYCLES for the back end to empty,
//   then raises SYS_req until the handler acks. Stall cycles are counted
//   in a saturating 16-bit counter for performance debug.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   ID__hazard_rs_id/_rt_id         source indices of the ID instruction
//   ID__hazard_uses_rt              ID instruction reads rt
//   stage_ID_EX__hazard_*           EX instruction: memread, sys_en, rs, rt
//   stage_EX_MEM__hazard_*          MEM instruction: regwrite, rd
//   stage_MEM_WB__hazard_*          WB instruction: regwrite, rd
//   SYS__hazard_ack                 system handler completion
//   hazard__IF_pc_stall             hold PC
//   hazard__stage_IF_ID_stall       hold IF/ID
//   hazard__stage_ID_EX_flush       insert bubble into ID/EX
//   hazard__EX_fwd_a/_fwd_b         operand source: 00 RF, 10 EX/MEM, 01 MEM/WB
//   hazard__SYS_req                 request to the system handler (registered)
//   hazard__stall_count             saturating stall-cycle count
module hazard_unit #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ID__hazard_rs_id,
  input  logic [4:0]  ID__hazard_rt_id,
  input  logic        ID__hazard_uses_rt,
  input  logic        stage_ID_EX__hazard_memread,
  input  logic        stage_ID_EX__hazard_sys_en,
  input  logic [4:0]  stage_ID_EX__hazard_rs_id,
  input  logic [4:0]  stage_ID_EX__hazard_rt_id,
  input  logic        stage_EX_MEM__hazard_regwrite,
  input  logic [4:0]  stage_EX_MEM__hazard_rd_id,
  input  logic        stage_MEM_WB__hazard_regwrite,
  input  logic [4:0]  stage_MEM_WB__hazard_rd_id,
  input  logic        SYS__hazard_ack,
  output logic        hazard__IF_pc_stall,
  output logic        hazard__stage_IF_ID_stall,
  output logic        hazard__stage_ID_EX_flush,
  output logic [1:0]  hazard__EX_fwd_a,
  output logic [1:0]  hazard__EX_fwd_b,
  output logic        hazard__SYS_req,
  output logic [15:0] hazard__stall_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    REQ   = 2'd2
  } state_t;

  // The counter is loaded with D-1 so that DRAIN lasts exactly D cycles
  // (the cnt==0 cycle is the last DRAIN cycle).
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        sys_req;
  logic [15:0] stall_count;
  logic        lu;
  logic        sys_hold;
  logic        stall;

  // EX/MEM is the younger producer, so it wins over MEM/WB. Register 0 is
  // hard-wired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       mem_rw,
    input logic [4:0] mem_rd,
    input logic       wb_rw,
    input logic [4:0] wb_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_rw && (mem_rd != 5'd0) && (mem_rd == src)) begin
      sel = 2'b10;
    end else if (wb_rw && (wb_rd != 5'd0) && (wb_rd == src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign hazard__EX_fwd_a = fwd_sel(stage_ID_EX__hazard_rs_id,
                                    stage_EX_MEM__hazard_regwrite, stage_EX_MEM__hazard_rd_id,
                                    stage_MEM_WB__hazard_regwrite, stage_MEM_WB__hazard_rd_id);
  assign hazard__EX_fwd_b = fwd_sel(stage_ID_EX__hazard_rt_id,
                                    stage_EX_MEM__hazard_regwrite, stage_EX_MEM__hazard_rd_id,
                                    stage_MEM_WB__hazard_regwrite, stage_MEM_WB__hazard_rd_id);

  // Load in EX whose destination is read by the ID instruction.
  assign lu = stage_ID_EX__hazard_memread
           && (stage_ID_EX__hazard_rt_id != 5'd0)
           && ((stage_ID_EX__hazard_rt_id == ID__hazard_rs_id)
               || (ID__hazard_uses_rt && (stage_ID_EX__hazard_rt_id == ID__hazard_rt_id)));

  // The syscall freezes the front end from the very cycle it sits in EX,
  // before the FSM has left IDLE.
  assign sys_hold = ((state == IDLE) && stage_ID_EX__hazard_sys_en) || (state != IDLE);
  assign stall    = lu || sys_hold;

  assign hazard__IF_pc_stall       = stall;
  assign hazard__stage_IF_ID_stall = stall;
  assign hazard__stage_ID_EX_flush = stall;
  assign hazard__SYS_req           = sys_req;
  assign hazard__stall_count       = stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      sys_req     <= 1'b0;
      stall_count <= 16'd0;
    end else begin
      if (stall && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
      case (state)
        IDLE: begin
          if (stage_ID_EX__hazard_sys_en) begin
            state <= DRAIN;
            cnt   <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (cnt == 4'd0) begin
            state   <= REQ;
            sys_req <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        REQ: begin
          if (SYS__hazard_ack) begin
            state   <= IDLE;
            sys_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          sys_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit
module tb_hazard_unit;

  localparam int D = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt;
  logic        id_uses_rt;
  logic        ex_memread, ex_sys_en;
  logic [4:0]  ex_rs, ex_rt;
  logic        mem_rw, wb_rw;
  logic [4:0]  mem_rd, wb_rd;
  logic        ack;
  logic        pc_stall, ifid_stall, idex_flush, sys_req;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_count;

  int tests = 0;
  int failed = 0;

  // Reference model: a syscall is a pending interval on a cycle timeline.
  bit m_busy;
  int m_req_start;
  int cyc;
  int m_count;
  bit m_stall, m_req;

  hazard_unit #(.DRAIN_CYCLES(D)) dut (
    .clk                           (clk),
    .rst_n                         (rst_n),
    .ID__hazard_rs_id              (id_rs),
    .ID__hazard_rt_id              (id_rt),
    .ID__hazard_uses_rt            (id_uses_rt),
    .stage_ID_EX__hazard_memread   (ex_memread),
    .stage_ID_EX__hazard_sys_en    (ex_sys_en),
    .stage_ID_EX__hazard_rs_id     (ex_rs),
    .stage_ID_EX__hazard_rt_id     (ex_rt),
    .stage_EX_MEM__hazard_regwrite (mem_rw),
    .stage_EX_MEM__hazard_rd_id    (mem_rd),
    .stage_MEM_WB__hazard_regwrite (wb_rw),
    .stage_MEM_WB__hazard_rd_id    (wb_rd),
    .SYS__hazard_ack               (ack),
    .hazard__IF_pc_stall           (pc_stall),
    .hazard__stage_IF_ID_stall     (ifid_stall),
    .hazard__stage_ID_EX_flush     (idex_flush),
    .hazard__EX_fwd_a              (fwd_a),
    .hazard__EX_fwd_b              (fwd_b),
    .hazard__SYS_req               (sys_req),
    .hazard__stall_count           (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] ex_rs, ex_rt;
    logic       mem_rw;
    logic [4:0] mem_rd;
    logic       wb_rw;
    logic [4:0] wb_rd;
    logic       memread;
    logic [4:0] id_rs, id_rt;
    logic       uses_rt;
    logic [1:0] fa, fb;
    logic       stall;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (mem_rw && mem_rd != 0 && mem_rd == src) return 2'b10;
    if (wb_rw && wb_rd != 0 && wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_uses_rt = 0;
    ex_memread = 0; ex_sys_en = 0; ex_rs = 0; ex_rt = 0;
    mem_rw = 0; mem_rd = 0; wb_rw = 0; wb_rd = 0; ack = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_busy = 0; m_count = 0; cyc = 0; m_req_start = 0;
  endtask

  // Called 1 time unit after a rising edge with inputs already applied.
  task automatic settle();
    logic lu;
    #3;
    lu = ex_memread && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    m_req   = m_busy && (cyc >= m_req_start);
    m_stall = lu || m_busy || ex_sys_en;
    check("fwd_a", fwd_a, ref_fwd(ex_rs));
    check("fwd_b", fwd_b, ref_fwd(ex_rt));
    check("pc_stall", pc_stall, m_stall);
    check("if_id_stall", ifid_stall, m_stall);
    check("id_ex_flush", idex_flush, m_stall);
    check("sys_req", sys_req, m_req);
    check("stall_count", stall_count, m_count);
  endtask

  task automatic tick();
    if (m_stall && m_count < 65535) m_count++;
    if (!m_busy && ex_sys_en) begin
      m_busy = 1;
      m_req_start = cyc + D + 1;
    end else if (m_req && ack) begin
      m_busy = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 5'd0, 1'b0, 2'b10, 2'b10, 1'b0};
    vecs[1] = '{5'd5, 5'd5, 1'b0, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 5'd0, 1'b0, 2'b01, 2'b01, 1'b0};
    vecs[2] = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0};
    vecs[3] = '{5'd3, 5'd9, 1'b1, 5'd9, 1'b1, 5'd3, 1'b0, 5'd0, 5'd0, 1'b0, 2'b01, 2'b10, 1'b0};
    vecs[4] = '{5'd0, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 5'd0, 1'b0, 2'b00, 2'b00, 1'b1};
    vecs[5] = '{5'd0, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1, 5'd7, 1'b0, 2'b00, 2'b00, 1'b0};
    vecs[6] = '{5'd0, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1, 5'd7, 1'b1, 2'b00, 2'b00, 1'b1};
    vecs[7] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b1, 2'b00, 2'b00, 1'b0};

    // Reset state
    do_reset();
    settle();
    check("reset_stall", pc_stall, 1'b0);
    check("reset_sys_req", sys_req, 1'b0);
    check("reset_count", stall_count, 16'd0);
    tick();

    // Table-driven combinational vectors
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      ex_rs = vecs[i].ex_rs; ex_rt = vecs[i].ex_rt;
      mem_rw = vecs[i].mem_rw; mem_rd = vecs[i].mem_rd;
      wb_rw = vecs[i].wb_rw; wb_rd = vecs[i].wb_rd;
      ex_memread = vecs[i].memread;
      id_rs = vecs[i].id_rs; id_rt = vecs[i].id_rt; id_uses_rt = vecs[i].uses_rt;
      settle();
      check($sformatf("vec%0d_fwd_a", i), fwd_a, vecs[i].fa);
      check($sformatf("vec%0d_fwd_b", i), fwd_b, vecs[i].fb);
      check($sformatf("vec%0d_stall", i), idex_flush, vecs[i].stall);
      tick();
    end

    // Load-use: one stall, bubble clears it
    do_reset();
    ex_memread = 1; ex_rt = 7; id_rs = 7;
    settle();
    check("lu_stall", pc_stall, 1'b1);
    tick();
    ex_memread = 0; ex_rt = 0;
    settle();
    check("lu_bubble_stall", pc_stall, 1'b0);
    check("lu_count", stall_count, 16'd1);
    tick();

    // Syscall drain D=3: sys_en at 10, ack at 16
    do_reset();
    for (int c = 0; c <= 17; c++) begin
      ex_sys_en = (c == 10);
      ack = (c == 16);
      settle();
      if (c >= 9) begin
        check($sformatf("sys_stall_c%0d", c), pc_stall, (c >= 10 && c <= 16));
        check($sformatf("sys_req_c%0d", c), sys_req, (c >= 14 && c <= 16));
      end
      if (c == 17) check("sys_count", stall_count, 16'd7);
      tick();
    end

    // Reset mid-drain: takes effect without a clock edge
    do_reset();
    ex_sys_en = 1;
    settle();
    tick();
    ex_sys_en = 0;
    settle();
    tick();
    settle();
    rst_n = 1'b0;
    #1;
    check("rst_drain_count", stall_count, 16'd0);
    check("rst_drain_stall", pc_stall, 1'b0);
    check("rst_drain_req", sys_req, 1'b0);
    // Reset mid-request
    do_reset();
    ex_sys_en = 1;
    settle();
    tick();
    ex_sys_en = 0;
    for (int c = 0; c < D + 1; c++) begin
      settle();
      tick();
    end
    settle();
    check("pre_rst_req", sys_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_req_req", sys_req, 1'b0);
    check("rst_req_count", stall_count, 16'd0);

    // Simultaneous load-use and sys_en: single increment per cycle
    do_reset();
    ex_sys_en = 1; ex_memread = 1; ex_rt = 4; id_rs = 4;
    settle();
    check("both_stall", pc_stall, 1'b1);
    tick();
    idle_inputs();
    settle();
    check("both_count1", stall_count, 16'd1);
    tick();
    settle();
    check("both_count2", stall_count, 16'd2);
    tick();

    // Randomized against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
      id_uses_rt = 1'($urandom);
      ex_memread = ($urandom_range(0, 3) == 0);
      ex_sys_en = ($urandom_range(0, 19) == 0);
      ex_rs = 5'($urandom_range(0, 7)); ex_rt = 5'($urandom_range(0, 7));
      mem_rw = 1'($urandom); mem_rd = 5'($urandom_range(0, 7));
      wb_rw = 1'($urandom); wb_rd = 5'($urandom_range(0, 7));
      ack = ($urandom_range(0, 2) == 0);
      settle();
      tick();
    end

    // Saturation: park in REQ with ack low for over 65535 cycles
    do_reset();
    ex_sys_en = 1;
    settle();
    tick();
    ex_sys_en = 0;
    repeat (65600) @(posedge clk);
    cyc += 65600;
    m_count = (m_count + 65600 > 65535) ? 65535 : m_count + 65600;
    settle();
    check("sat_count", stall_count, 16'hFFFF);
    tick();
    settle();
    check("sat_hold", stall_count, 16'hFFFF);
    ack = 1;
    tick();
    ack = 0;
    settle();
    check("sat_after_ack", stall_count, 16'hFFFF);
    check("sat_released", pc_stall, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
